// File: rtl/fifo_drain_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_drain_ctrl
//   Read-side master for fifo_mem. Issues fifo_rd pulses in bursts (started by
//   threshold or flush), captures fifo_data RD_LATENCY cycles later into a
//   small circular output buffer, and presents the buffer head on a
//   valid/ready stream. Reads are only issued when the buffer has room for
//   every word already in flight, so a push never meets a full buffer.
//
// Parameters
//   DATA_WIDTH  word width (matches fifo_mem)
//   BURST_LEN   max reads per burst
//   RD_LATENCY  fifo_rd -> fifo_data latency (1 or 2)
//   OUT_DEPTH   output buffer entries (power of 2, >= RD_LATENCY+1)
//
// Ports
//   clk, rst_n              clock / async active-low reset
//   enable                  allow new bursts to start
//   flush                   start a burst regardless of threshold (level)
//   fifo_empty, fifo_thr    fifo_mem status
//   fifo_data               fifo_mem read data
//   fifo_rd                 fifo_mem read strobe
//   m_data, m_valid, m_ready  output stream
//   busy                    FSM active, reads in flight or buffer non-empty
//   word_cnt                accepted stream beats, wraps at 2^16
//
// Optional build macro SEQ_CHECK_EN adds seq_err / seq_exp: a running
// sequence checker on accepted beats (expects 1,2,3,...; sticky error).
// ----------------------------------------------------------------------------
module fifo_drain_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int BURST_LEN  = 4,
   parameter int RD_LATENCY = 1,
   parameter int OUT_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  flush,
   input  logic                  fifo_empty,
   input  logic                  fifo_thr,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic [15:0]           word_cnt
`ifdef SEQ_CHECK_EN
   ,
   output logic                  seq_err,
   output logic [DATA_WIDTH-1:0] seq_exp
`endif
);

   localparam int PW = $clog2(OUT_DEPTH);
   localparam int BW = $clog2(BURST_LEN + 1);
   localparam int CW = PW + 2;   // holds occ + inflight without overflow

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

   state_t                r_state;
   logic [BW-1:0]         r_beat_cnt;
   logic [RD_LATENCY-1:0] r_vld_pipe;
   logic [PW:0]           r_wr_ptr;
   logic [PW:0]           r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_mem [OUT_DEPTH];
   logic [15:0]           r_word_cnt;

   logic [PW:0]           w_occ;
   logic [CW-1:0]         w_inflight;
   logic [CW-1:0]         w_credit;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_start;

   // Pointers carry one extra bit so full and empty are distinguishable.
   assign w_occ    = r_wr_ptr - r_rd_ptr;
   assign w_push   = r_vld_pipe[RD_LATENCY-1];
   assign m_valid  = (w_occ != '0);
   assign m_data   = r_mem[r_rd_ptr[PW-1:0]];
   assign w_pop    = m_valid & m_ready;
   assign w_start  = enable & (fifo_thr | flush) & ~fifo_empty;
   assign word_cnt = r_word_cnt;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++)
         w_inflight = w_inflight + CW'(r_vld_pipe[i]);
   end

   // Reserve a slot for every word still in flight before issuing another.
   assign w_credit = CW'(w_occ) + w_inflight;
   assign fifo_rd  = (r_state == S_BURST) & ~fifo_empty
                   & (r_beat_cnt < BW'(BURST_LEN))
                   & (w_credit < CW'(OUT_DEPTH));

   assign busy = (r_state != S_IDLE) | (w_inflight != '0) | m_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state    <= S_BURST;
                  r_beat_cnt <= '0;
               end
            end
            S_BURST: begin
               if (fifo_rd)
                  r_beat_cnt <= r_beat_cnt + 1'b1;
               // Burst ends on the last beat or as soon as the source runs dry;
               // a credit stall just waits.
               if ((fifo_rd && r_beat_cnt == BW'(BURST_LEN - 1)) || fifo_empty ||
                   r_beat_cnt >= BW'(BURST_LEN))
                  r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_inflight == '0)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
      end else begin
         r_vld_pipe[0] <= fifo_rd;
         for (int i = 1; i < RD_LATENCY; i++)
            r_vld_pipe[i] <= r_vld_pipe[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_word_cnt <= '0;
         for (int i = 0; i < OUT_DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= fifo_data;
            r_wr_ptr                <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_word_cnt <= r_word_cnt + 16'd1;
         end
      end
   end

`ifdef SEQ_CHECK_EN
   logic                  r_seq_err;
   logic [DATA_WIDTH-1:0] r_seq_exp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seq_err <= 1'b0;
         r_seq_exp <= DATA_WIDTH'(1);
      end else if (w_pop) begin
         if (m_data != r_seq_exp)
            r_seq_err <= 1'b1;
         // Resync on whatever arrived so one gap reports once.
         r_seq_exp <= m_data + 1'b1;
      end
   end

   assign seq_err = r_seq_err;
   assign seq_exp = r_seq_exp;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
module tb_fifo_drain_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1;
   logic        flush = 1'b0;
   logic        fifo_empty = 1'b1;
   logic        fifo_thr = 1'b0;
   logic [15:0] fifo_data = '0;
   logic        fifo_rd;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic        busy;
   logic [15:0] word_cnt;
`ifdef SEQ_CHECK_EN
   logic        seq_err;
   logic [15:0] seq_exp;
`endif

   fifo_drain_ctrl #(.DATA_WIDTH(16), .BURST_LEN(4), .RD_LATENCY(1), .OUT_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
      .fifo_empty(fifo_empty), .fifo_thr(fifo_thr), .fifo_data(fifo_data),
      .fifo_rd(fifo_rd), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .word_cnt(word_cnt)
`ifdef SEQ_CHECK_EN
      , .seq_err(seq_err), .seq_exp(seq_exp)
`endif
   );

   always #5 clk = ~clk;

   // fifo_mem model: 1-cycle read latency
   logic [15:0] fifo_q[$];
   logic [15:0] exp_q[$];
   logic [15:0] rx_q[$];
   logic        rd_s = 1'b0;
   int          rd_cnt = 0;
   int          uflow = 0;

   always @(negedge clk) begin
      rd_s = fifo_rd;
      if (fifo_rd) rd_cnt++;
      if (rst_n && m_valid && m_ready) rx_q.push_back(m_data);
   end

   always @(posedge clk) begin
      if (rd_s) begin
         if (fifo_q.size() == 0) uflow++;
         else fifo_data <= fifo_q.pop_front();
      end
      fifo_empty <= (fifo_q.size() == 0);
   end

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_val(input logic [15:0] v);
      fifo_q.push_back(v);
      exp_q.push_back(v);
   endtask

   task automatic run(input bit en, input bit thr, input bit fl, input bit tog, output int rds);
      int  r0;
      bit  done;
      r0 = rd_cnt;
      enable = en; fifo_thr = thr; flush = fl;
      tick();
      fifo_thr = 1'b0; flush = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         m_ready = tog ? ~m_ready : 1'b1;
         tick();
         if (!busy && !m_valid) done = 1'b1;
      end
      m_ready = 1'b1; enable = 1'b1;
      if (!done) chk("run_timeout", 0, 1);
      rds = rd_cnt - r0;
   endtask

   task automatic check_rx(input int n);
      logic [15:0] v, e;
      chk("rx_count", rx_q.size(), n);
      while (rx_q.size() > 0) begin
         v = rx_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
         chk("rx_data", v, e);
      end
   endtask

   typedef struct {
      int n;      // words added to the FIFO before the run
      bit en, thr, fl, tog;
      int rd;     // expected reads (= words delivered)
      int wc;     // expected word_cnt after the run
   } vec_t;

   vec_t tbl[9];
   int   nextval;
   int   rds;
   int   r0;
   logic [15:0] first;

   initial begin
      tbl[0] = '{6,  1, 1, 0, 0, 4, 4};    // threshold burst capped at BURST_LEN
      tbl[1] = '{0,  1, 0, 1, 0, 2, 6};    // flush leftovers, empty gating
      tbl[2] = '{2,  1, 0, 1, 0, 2, 8};    // flush with 2 words
      tbl[3] = '{4,  0, 1, 0, 0, 0, 8};    // enable low: no burst
      tbl[4] = '{0,  1, 0, 1, 0, 4, 12};
      tbl[5] = '{16, 1, 1, 0, 1, 4, 16};   // toggling ready over 16 words
      tbl[6] = '{0,  1, 1, 0, 1, 4, 20};
      tbl[7] = '{0,  1, 1, 0, 1, 4, 24};
      tbl[8] = '{0,  1, 0, 1, 1, 4, 28};

      // reset state
      repeat (3) tick();
      chk("rst_valid", m_valid, 0);
      chk("rst_rd", fifo_rd, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wcnt", word_cnt, 0);
      chk("rst_data", m_data, 0);
      rst_n = 1'b1;
      tick();

      // reset mid-burst with words buffered
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) fifo_q.push_back(16'(900 + i));
      tick(); tick();
      fifo_thr = 1'b1;
      tick();
      fifo_thr = 1'b0;
      repeat (3) tick();
      chk("mid_valid_pre", m_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_rd", fifo_rd, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_wcnt", word_cnt, 0);
      tick();
      rst_n = 1'b1;
      r0 = rd_cnt;
      repeat (5) tick();
      chk("mid_rst_noread", rd_cnt - r0, 0);
      chk("mid_rst_idle", busy, 0);
      fifo_q.delete();
      rx_q.delete();
      m_ready = 1'b1;
      tick(); tick();

      // table-driven bursts
      nextval = 1;
      for (int k = 0; k < 9; k++) begin
         for (int j = 0; j < tbl[k].n; j++) begin
            load_val(16'(nextval));
            nextval++;
         end
         tick(); tick();
         run(tbl[k].en, tbl[k].thr, tbl[k].fl, tbl[k].tog, rds);
         chk($sformatf("v%0d_reads", k), rds, tbl[k].rd);
         check_rx(tbl[k].rd);
         chk($sformatf("v%0d_wcnt", k), word_cnt, tbl[k].wc);
      end
      chk("fifo_drained", fifo_q.size(), 0);

      // backpressure: reads limited by buffer credit, head held stable
      m_ready = 1'b0;
      first = 16'(nextval);
      for (int j = 0; j < 8; j++) begin
         load_val(16'(nextval));
         nextval++;
      end
      tick(); tick();
      r0 = rd_cnt;
      fifo_thr = 1'b1;
      tick();
      fifo_thr = 1'b0;
      repeat (8) tick();
      chk("bp_reads", rd_cnt - r0, 4);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", m_valid, 1);
         chk("bp_hold", m_data, first);
         tick();
      end
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("bp_rel_valid", m_valid, 1);
         chk("bp_rel_data", m_data, first + 16'(i));
         tick();
      end
      chk("bp_empty", m_valid, 0);
      chk("bp_busy", busy, 0);
      check_rx(4);
      run(1, 0, 1, 0, rds);
      chk("bp_tail_reads", rds, 4);
      check_rx(4);
      chk("bp_wcnt", word_cnt, 36);

      // reset clears the running count
      rst_n = 1'b0;
      #1;
      chk("end_rst_wcnt", word_cnt, 0);
      chk("end_rst_valid", m_valid, 0);
      tick();
      rst_n = 1'b1;
      tick();

`ifdef SEQ_CHECK_EN
      exp_q.delete();
      rx_q.delete();
      chk("seq_rst_err", seq_err, 0);
      chk("seq_rst_exp", seq_exp, 1);
      load_val(16'd1); load_val(16'd2); load_val(16'd3);
      tick(); tick();
      run(1, 0, 1, 0, rds);
      check_rx(3);
      chk("seq_ok_err", seq_err, 0);
      chk("seq_ok_exp", seq_exp, 4);
      load_val(16'd5); load_val(16'd6);
      tick(); tick();
      run(1, 0, 1, 0, rds);
      check_rx(2);
      chk("seq_gap_err", seq_err, 1);
      chk("seq_gap_exp", seq_exp, 7);
      repeat (2) tick();
      chk("seq_sticky", seq_err, 1);
`endif

      chk("no_underflow", uflow, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout act=1 exp=0");
      $fatal(1, "timeout");
   end

endmodule
